uart_tx_core: RTL and testbench

Parametrised UART transmit core that merges frame sequencing, serialization and parity generation into one block. It supports configurable data width, per-frame parity enable and type, and one or two stop bits. A one-entry holding buffer with a valid/ready handshake allows back-to-back frames with no idle bit between them. The core sits between the TX data source and the serial line pin, and CLK is the bit clock (one serial bit per CLK cycle).

---
 rtl/uart_tx_core_if.sv | 12 +
 rtl/uart_tx_core.sv | 126 ++++++++++++
 tb/tb_uart_tx_core.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_core_if.sv
// Source-side handshake for uart_tx_core: payload, per-frame config and valid/ready.
interface uart_tx_core_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  Data_Ready;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  STP2;

  modport master (output P_DATA, Data_Valid, PAR_EN, PAR_TYP, STP2, input Data_Ready);
  modport slave  (input P_DATA, Data_Valid, PAR_EN, PAR_TYP, STP2, output Data_Ready);
endinterface

// File: rtl/uart_tx_core.sv
// UART transmitter, one serial bit per CLK: one-entry hold buffer feeding a
// start/data/parity/stop sequencer with registered line output.
module uart_tx_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic            CLK,
  input  logic            RST,
  uart_tx_core_if.slave   src,
  output logic            TX_OUT,
  output logic            busy,
  output logic            frame_done
);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("uart_tx_core: DATA_WIDTH must be in 5..9");
  end

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  par_en;
    logic                  par_typ;
    logic                  stp2;
  } frame_t;

  state_t                state;
  frame_t                hold;
  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] shift;
  logic [CW-1:0]         cnt;
  logic                  par_en_q;
  logic                  stp2_q;
  logic                  par_bit;
  logic                  final_stop;
  logic                  start_next;

  assign src.Data_Ready = ~hold_valid;

  // Last stop cycle of the current frame; a pending hold chains straight into START.
  assign final_stop = (state == STOP2) || (state == STOP1 && !stp2_q);
  assign start_next = hold_valid && (state == IDLE || final_stop);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      hold       <= '0;
      hold_valid <= 1'b0;
      shift      <= '0;
      cnt        <= '0;
      par_en_q   <= 1'b0;
      stp2_q     <= 1'b0;
      par_bit    <= 1'b0;
      TX_OUT     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (start_next) begin
        state      <= START;
        shift      <= hold.data;
        par_en_q   <= hold.par_en;
        stp2_q     <= hold.stp2;
        par_bit    <= (^hold.data) ^ hold.par_typ;
        hold_valid <= 1'b0;
        TX_OUT     <= 1'b0;
        busy       <= 1'b1;
      end else begin
        case (state)
          START: begin
            state  <= DATA;
            cnt    <= '0;
            TX_OUT <= shift[0];
          end
          DATA: begin
            if (cnt == LAST) begin
              if (par_en_q) begin
                state  <= PARITY;
                TX_OUT <= par_bit;
              end else begin
                state      <= STOP1;
                TX_OUT     <= 1'b1;
                frame_done <= ~stp2_q;
              end
            end else begin
              cnt    <= cnt + 1'b1;
              shift  <= {1'b0, shift[DATA_WIDTH-1:1]};
              TX_OUT <= shift[1];
            end
          end
          PARITY: begin
            state      <= STOP1;
            TX_OUT     <= 1'b1;
            frame_done <= ~stp2_q;
          end
          STOP1: begin
            if (stp2_q) begin
              state      <= STOP2;
              frame_done <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          STOP2: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            TX_OUT <= 1'b1;
            busy   <= 1'b0;
          end
        endcase
      end
      // Accept and transfer never coincide: accept needs an empty hold, transfer a full one.
      if (src.Data_Valid && !hold_valid) begin
        hold       <= {src.P_DATA, src.PAR_EN, src.PAR_TYP, src.STP2};
        hold_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: DATA_WIDTH=8 and DATA_WIDTH=5 instances.
module tb_uart_tx_core;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic tx8, busy8, fd8, tx5, busy5, fd5;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 CLK = ~CLK;

  uart_tx_core_if #(.DATA_WIDTH(8)) if8();
  uart_tx_core_if #(.DATA_WIDTH(5)) if5();

  uart_tx_core #(.DATA_WIDTH(8)) u8 (
    .CLK(CLK), .RST(RST), .src(if8.slave),
    .TX_OUT(tx8), .busy(busy8), .frame_done(fd8)
  );
  uart_tx_core #(.DATA_WIDTH(5)) u5 (
    .CLK(CLK), .RST(RST), .src(if5.slave),
    .TX_OUT(tx5), .busy(busy5), .frame_done(fd5)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for ready, then presents one frame for exactly one accepting edge.
  task automatic send(input bit w5, input logic [7:0] d, input logic pe, pt, s2);
    int t = 0;
    while (!(w5 ? if5.Data_Ready : if8.Data_Ready) && t < 64) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 64) chk("ready_timeout", 32'd0, 32'd1);
    if (w5) begin
      if5.P_DATA = d[4:0]; if5.PAR_EN = pe; if5.PAR_TYP = pt; if5.STP2 = s2;
      if5.Data_Valid = 1'b1;
    end else begin
      if8.P_DATA = d; if8.PAR_EN = pe; if8.PAR_TYP = pt; if8.STP2 = s2;
      if8.Data_Valid = 1'b1;
    end
    @(posedge CLK);
    #1;
    if5.Data_Valid = 1'b0;
    if8.Data_Valid = 1'b0;
  endtask

  // Called just after the accepting edge; skips that idle half-cycle, then records
  // len frame cycles, first cycle in the MSB position.
  task automatic capture(input bit w5, input int len,
                         output logic [31:0] tx, output logic [31:0] bz, output logic [31:0] fd);
    tx = '0; bz = '0; fd = '0;
    @(negedge CLK);
    for (int i = 0; i < len; i++) begin
      @(negedge CLK);
      tx = {tx[30:0], w5 ? tx5 : tx8};
      bz = {bz[30:0], w5 ? busy5 : busy8};
      fd = {fd[30:0], w5 ? fd5 : fd8};
    end
  endtask

  task automatic idle_chk(input string tag, input bit w5);
    @(negedge CLK);
    chk({tag, "_idle_tx"},   32'(w5 ? tx5 : tx8), 32'd1);
    chk({tag, "_idle_busy"}, 32'(w5 ? busy5 : busy8), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tx, bz, fd;
    if8.P_DATA = '0; if8.Data_Valid = 0; if8.PAR_EN = 0; if8.PAR_TYP = 0; if8.STP2 = 0;
    if5.P_DATA = '0; if5.Data_Valid = 0; if5.PAR_EN = 0; if5.PAR_TYP = 0; if5.STP2 = 0;
    repeat (2) @(negedge CLK);
    chk("rst_tx",    32'(tx8), 32'd1);
    chk("rst_busy",  32'(busy8), 32'd0);
    chk("rst_ready", 32'(if8.Data_Ready), 32'd1);
    chk("rst_fd",    32'(fd8), 32'd0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // 0xA5, even parity, one stop
    send(0, 8'hA5, 1, 0, 0);
    chk("basic_ready_low", 32'(if8.Data_Ready), 32'd0);
    capture(0, 11, tx, bz, fd);
    chk("basic_tx",   tx, 32'b01010010101);
    chk("basic_busy", bz, 32'h7FF);
    chk("basic_fd",   fd, 32'b1);
    idle_chk("basic", 0);

    // Reset during DATA with a second frame already waiting in the hold
    send(0, 8'hA5, 1, 0, 0);
    send(0, 8'h3C, 1, 1, 1);
    @(negedge CLK);
    chk("pre_rst_data_bit", 32'(tx8), 32'd1);
    #2 RST = 1'b0;
    #1;
    chk("midrst_tx",    32'(tx8), 32'd1);
    chk("midrst_busy",  32'(busy8), 32'd0);
    chk("midrst_ready", 32'(if8.Data_Ready), 32'd1);
    chk("midrst_fd",    32'(fd8), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("postrst_busy", 32'(busy8), 32'd0);
    chk("postrst_tx",   32'(tx8), 32'd1);

    // 0x3C, odd parity, two stops
    send(0, 8'h3C, 1, 1, 1);
    capture(0, 12, tx, bz, fd);
    chk("odd_tx",   tx, 32'b000111100111);
    chk("odd_busy", bz, 32'hFFF);
    chk("odd_fd",   fd, 32'b1);
    idle_chk("odd", 0);

    // Back-to-back: 0x55 then 0x0F as soon as ready returns
    send(0, 8'h55, 0, 0, 0);
    fork
      send(0, 8'h0F, 0, 0, 0);
      capture(0, 20, tx, bz, fd);
    join
    chk("b2b_tx",   tx, 32'b01010101010111100001);
    chk("b2b_busy", bz, 32'hFFFFF);
    chk("b2b_fd",   fd, 32'b00000000010000000001);
    idle_chk("b2b", 0);

    // Backpressure: valid held with changing junk while hold is full
    send(0, 8'h11, 0, 0, 0);
    fork
      begin
        int t = 0;
        send(0, 8'h22, 0, 0, 0);
        if8.P_DATA = 8'h5A;
        if8.Data_Valid = 1'b1;
        @(negedge CLK);
        chk("bp_ready_low", 32'(if8.Data_Ready), 32'd0);
        while (!if8.Data_Ready && t < 64) begin
          if8.P_DATA = if8.P_DATA + 8'h13;
          @(negedge CLK);
          t++;
        end
        if (t >= 64) chk("bp_ready_timeout", 32'd0, 32'd1);
        if8.P_DATA = 8'hC3;
        @(posedge CLK);
        #1 if8.Data_Valid = 1'b0;
      end
      capture(0, 30, tx, bz, fd);
    join
    chk("bp_tx",   tx, 32'b010001000100100010010110000111);
    chk("bp_busy", bz, 32'h3FFFFFFF);
    chk("bp_fd",   fd, 32'b000000000100000000010000000001);
    idle_chk("bp", 0);

    // DATA_WIDTH=5: 5'b10011, even parity, one stop
    send(1, 8'h13, 1, 0, 0);
    capture(1, 8, tx, bz, fd);
    chk("w5_tx",   tx, 32'b01100111);
    chk("w5_busy", bz, 32'hFF);
    chk("w5_fd",   fd, 32'b1);
    idle_chk("w5", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
